// File: rtl/gry_bin_seq.sv
// gry_bin_seq: sequential Gray-to-binary converter.
// Accepts one N-bit Gray word through a valid/ready handshake and resolves
// one binary bit per clock, MSB first. It then holds the result under a
// valid/ready handshake until the consumer takes it. Only one word is in
// flight at a time.
module gry_bin_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] gray,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] binary,
  output logic         busy
);

  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [N-1:0]     r_gray;
  logic [N-1:0]     r_work;
  logic [N-1:0]     r_binary;
  logic [IDX_W-1:0] r_idx;

  logic             w_accept;
  logic             w_release;
  logic             w_last;
  logic [IDX_W-1:0] w_idx_up;
  logic             w_bit;
  logic [N-1:0]     w_work_next;

  // Handshake qualifiers and the single-bit XOR step.
  // idx never exceeds N-2, so idx+1 always fits in IDX_W bits.
  assign w_accept  = in_valid && (r_state == S_IDLE);
  assign w_release = out_ready && (r_state == S_DONE);
  assign w_last    = (r_idx == '0);
  assign w_idx_up  = r_idx + IDX_W'(1);
  assign w_bit     = r_work[w_idx_up] ^ r_gray[r_idx];

  // Work word with the current bit resolved; this is what gets committed this cycle.
  always_comb begin
    w_work_next        = r_work;
    w_work_next[r_idx] = w_bit;
  end

  // State register; reset takes effect without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and the state-decoded handshake/status outputs.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (w_accept) begin
          w_state_next = S_CONV;
        end
      end
      S_CONV: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (w_release) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: capture on accept, resolve one bit per CONV cycle, and publish on the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gray   <= '0;
      r_work   <= '0;
      r_binary <= '0;
      r_idx    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_gray <= gray;
            // The MSB of the binary value equals the Gray MSB.
            r_work <= {gray[N-1], {(N-1){1'b0}}};
            r_idx  <= IDX_TOP;
          end
        end
        S_CONV: begin
          r_work <= w_work_next;
          if (w_last) begin
            r_binary <= w_work_next;
          end else begin
            r_idx <= r_idx - IDX_W'(1);
          end
        end
        default: begin
          // DONE holds everything until the consumer takes the result.
        end
      endcase
    end
  end

  assign binary = r_binary;

endmodule

// File: tb/tb_gry_bin_seq.sv
// Directed and randomized round-trip bench for gry_bin_seq (N = 8).
module tb_gry_bin_seq;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] gray;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] binary;
  logic         busy;

  int checks;
  int errors;

  gry_bin_seq #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .gray      (gray),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .binary    (binary),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge in IDLE. Runs one full conversion with out_ready
  // held high during CONV (which must have no effect) and releases the result.
  task automatic convert(input logic [N-1:0] g, input logic [N-1:0] exp, input logic [N-1:0] prev);
    gray = g;
    in_valid = 1'b1;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    gray = 8'($urandom);
    out_ready = 1'b1;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("in_ready_conv", 32'(in_ready), 32'd0);
    for (int i = 1; i <= N - 2; i++) begin
      @(negedge clk);
      chk("out_valid_early", 32'(out_valid), 32'd0);
      chk("binary_hold_conv", 32'(binary), 32'(prev));
    end
    @(negedge clk);
    chk("out_valid_rise", 32'(out_valid), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
    chk("binary_result", 32'(binary), 32'(exp));
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_fall", 32'(out_valid), 32'd0);
    chk("in_ready_back", 32'(in_ready), 32'd1);
    chk("binary_retain", 32'(binary), 32'(exp));
    $display("convert gray=%02h binary=%02h expected=%02h", g, binary, exp);
  endtask

  initial begin
    logic [N-1:0] q[$];
    logic [N-1:0] b_cur;
    logic [N-1:0] e;
    int sent;
    int got;
    int cyc;
    int seen_ov;

    checks = 0;
    errors = 0;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    gray = '0;

    // Reset values while reset is held
    #1 rst = 1'b1;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_binary", 32'(binary), 32'd0);
    $display("reset state in_ready=%0b out_valid=%0b busy=%0b binary=%02h", in_ready, out_valid, busy, binary);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors; the first is offered on the very first edge after reset release
    convert(8'b1100_1010, 8'b1000_1100, 8'h00);
    convert(8'h80, 8'hFF, 8'b1000_1100);
    convert(8'h00, 8'h00, 8'hFF);
    convert(8'h01, 8'h01, 8'h00);
    convert(8'hFF, 8'hAA, 8'h01);

    // Backpressure: result held for 5 cycles while a second word is offered
    gray = 8'h5A;  // 5A -> 6C
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 1; i <= N - 1; i++) @(negedge clk);
    chk("bp_out_valid_rise", 32'(out_valid), 32'd1);
    in_valid = 1'b1;
    gray = 8'h33;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_binary", 32'(binary), 32'h6C);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bp_out_valid_end", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_released", 32'(out_valid), 32'd0);
    chk("bp_in_ready", 32'(in_ready), 32'd1);
    chk("bp_busy", 32'(busy), 32'd0);
    $display("backpressure binary=%02h expected=6c", binary);

    // Retained result is visible through the next conversion
    convert(8'h0F, 8'h0A, 8'h6C);

    // Asynchronous reset 3 cycles into a conversion
    gray = 8'hC3;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_binary", 32'(binary), 32'd0);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    seen_ov = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen_ov++;
    end
    out_ready = 1'b0;
    chk("abort_no_out_valid", 32'(seen_ov), 32'd0);
    chk("abort_idle", 32'(in_ready), 32'd1);
    $display("reset abort out_valid_pulses=%0d", seen_ov);

    // Random round trip with random gaps on both sides
    sent = 0;
    got = 0;
    cyc = 0;
    b_cur = 8'($urandom);
    while (got < 100 && cyc < 5000) begin
      cyc++;
      out_ready = ($urandom_range(0, 2) != 0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rt_spurious", 32'(binary), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("rt_value", 32'(binary), 32'(e));
          $display("roundtrip %0d binary=%02h expected=%02h", got, binary, e);
        end
        got++;
      end
      in_valid = (sent < 100) && ($urandom_range(0, 2) != 0);
      if (in_ready) gray = b_cur ^ (b_cur >> 1);
      else gray = 8'($urandom);
      if (in_valid && in_ready) begin
        q.push_back(b_cur);
        sent++;
        b_cur = 8'($urandom);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("rt_count", 32'(got), 32'd100);
    chk("rt_queue_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gry_bin_seq.md
GRY_BIN_SEQ -- requirements
Module: gry_bin_seq

Interface
REQ-001 Parameter: N, default 8, data width in bits; legal range N >= 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  gray input word is presented.
REQ-005 in_ready  output  1  block can accept an input word.
REQ-006 gray  input  N  Gray-coded input word.
REQ-007 out_valid  output  1  binary result is available.
REQ-008 out_ready  input  1  consumer accepts the result.
REQ-009 binary  output  N  converted binary result.
REQ-010 busy  output  1  high while a conversion is in progress (state CONV).

Function
REQ-011 The block SHALL be a three-state FSM: IDLE, CONV, DONE.
REQ-012 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; busy SHALL be 1 only in CONV.
REQ-013 Input handshake: in_valid && in_ready at a rising edge; gray SHALL be captured into an internal N-bit register on that edge.
REQ-014 On the accept edge, work bit N-1 SHALL be set to gray[N-1], bit index SHALL load N-2, and the state SHALL go IDLE -> CONV.
REQ-015 In CONV, each edge SHALL compute work[idx] = work[idx+1] ^ g_reg[idx], then decrement idx; exactly one bit per cycle, MSB to LSB.
REQ-016 The edge that computes bit 0 SHALL copy the full work word to the binary output register and move CONV -> DONE.
REQ-017 Latency: out_valid SHALL rise exactly N-1 clock edges after the accept edge (7 for N=8); throughput is one word per N+1 cycles minimum.
REQ-018 In DONE, out_valid and binary SHALL stay stable until out_valid && out_ready at an edge; that edge SHALL move DONE -> IDLE.
REQ-019 No overlap: a new word SHALL NOT be accepted in CONV or DONE; in_valid and gray SHALL be ignored in those states.
REQ-020 The binary output register SHALL change only on the CONV -> DONE edge and on reset; it retains the last result in IDLE and CONV.
REQ-021 The result SHALL satisfy binary[i] = XOR of gray[N-1:i] for all i; it is the exact inverse of the team's binary-to-Gray mapping (gray = binary ^ (binary >> 1)).
REQ-022 out_ready asserted outside DONE SHALL have no effect.
REQ-023 The bit index counter SHALL be ceil(log2(N)) bits wide and SHALL NOT wrap below 0; the exit decision uses idx == 0.

Reset
REQ-024 rst high SHALL immediately, without waiting for clk, force: state IDLE, in_ready 1, out_valid 0, busy 0, binary 0, internal gray/work registers 0, idx 0.
REQ-025 Reset asserted mid-conversion or in DONE SHALL abort the word; no out_valid pulse for it SHALL follow after reset release.
REQ-026 The first edge after rst deasserts SHALL be able to accept a word (in_ready is already 1).

Verification
REQ-027 N=8, gray 8'b1100_1010 accepted, out_ready=1 -> out_valid high 7 edges after accept, binary 8'b1000_1100, then IDLE and in_ready=1.
REQ-028 gray 8'h80 -> binary 8'hFF; gray 8'h00 -> 8'h00; gray 8'h01 -> 8'h01; gray 8'hFF -> 8'hAA.
REQ-029 Backpressure: result ready with out_ready=0 for 5 cycles -> out_valid stays 1, binary stable, in_ready 0; a second in_valid word offered meanwhile is not taken.
REQ-030 Reset mid-operation: rst pulsed asynchronously 3 cycles after accept -> outputs go to reset values before the next edge; no out_valid for the aborted word.
REQ-031 Round-trip: 100 random binary values b, drive gray = b ^ (b >> 1) with random in_valid/out_ready gaps -> every result equals b, in order, none dropped or duplicated.
